// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    rx_idle       = 2'd0,
    rx_data_bits  = 2'd1,
    rx_parity_bit = 2'd2,
    rx_stop_bit   = 2'd3
  } rx_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned CNT_W      = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] MID_START = CNT_W'(7);
  localparam logic [CNT_W-1:0] SAMPLE_PT = CNT_W'(15);

  // 7-bit frames land in [7:1] of the shift register; right-justify them.
  function automatic logic [7:0] justify(input logic [7:0] sr, input logic bit8);
    return bit8 ? sr : {1'b0, sr[7:1]};
  endfunction

endpackage

// File: rtl/uart_rx_filter.sv
// Input conditioning for the serial line: 2-flop synchroniser followed by a
// 3-tap majority vote that only advances on baud ticks.
module uart_rx_filter (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic baud_clock_i,
  input  logic rx_i,
  output logic rx_filt_o
);

  logic       sync1_q, sync2_q;
  logic [2:0] taps_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      taps_q  <= 3'b111;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      if (baud_clock_i) taps_q <= {taps_q[1:0], sync2_q};
    end
  end

  assign rx_filt_o = (taps_q[0] & taps_q[1]) | (taps_q[0] & taps_q[2]) | (taps_q[1] & taps_q[2]);

endmodule

// File: rtl/uart_rx_async.sv
// 16x oversampling UART receiver: 7/8 data bits, optional parity, delivery to a
// holding register or as an active-low strobe into an external RX FIFO.
//
// state         | meaning
// rx_idle       | line idle; qualifying start bit by counting low ticks
// rx_data_bits  | sampling data bits at the middle of each bit
// rx_parity_bit | sampling the parity bit
// rx_stop_bit   | sampling the stop bit, then back to idle mid-stop-bit
module uart_rx_async
  import uart_pkg::*;
#(
  parameter int unsigned RX_FIFO = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_clock,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  input  logic       clear_status,
  input  logic       fifo_full,
  output logic [7:0] rx_byte,
  output logic       receive_full,
  output logic       fifo_write_rx,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow
);

  rx_state_e        state_q;
  logic [CNT_W-1:0] samp_cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic             perr_q, stop_q, done_q;
  logic             rx_filt;
  logic [7:0]       data_d;
  logic [2:0]       last_bit_d;

  logic [7:0] rx_byte_q;
  logic       receive_full_q, fifo_write_rx_q;
  logic       parity_err_q, framing_err_q, overflow_q;

  uart_rx_filter u_filter (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .baud_clock_i (baud_clock),
    .rx_i         (rx),
    .rx_filt_o    (rx_filt)
  );

  assign data_d     = justify(shift_q, bit8);
  assign last_bit_d = bit8 ? 3'd7 : 3'd6;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= rx_idle;
      samp_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      stop_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (baud_clock) begin
        case (state_q)
          rx_idle: begin
            if (rx_filt) begin
              samp_cnt_q <= '0;
            end else if (samp_cnt_q == MID_START) begin
              samp_cnt_q <= '0;
              bit_cnt_q  <= '0;
              perr_q     <= 1'b0;
              state_q    <= rx_data_bits;
            end else begin
              samp_cnt_q <= samp_cnt_q + CNT_W'(1);
            end
          end
          rx_data_bits: begin
            samp_cnt_q <= samp_cnt_q + CNT_W'(1);
            if (samp_cnt_q == SAMPLE_PT) begin
              shift_q   <= {rx_filt, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == last_bit_d)
                state_q <= parity_en ? rx_parity_bit : rx_stop_bit;
            end
          end
          rx_parity_bit: begin
            samp_cnt_q <= samp_cnt_q + CNT_W'(1);
            if (samp_cnt_q == SAMPLE_PT) begin
              perr_q  <= (^data_d) ^ rx_filt ^ odd_n_even;
              state_q <= rx_stop_bit;
            end
          end
          rx_stop_bit: begin
            samp_cnt_q <= samp_cnt_q + CNT_W'(1);
            if (samp_cnt_q == SAMPLE_PT) begin
              stop_q     <= rx_filt;
              done_q     <= 1'b1;
              samp_cnt_q <= '0;
              state_q    <= rx_idle;
            end
          end
          default: state_q <= rx_idle;
        endcase
      end
    end
  end

  // Completion is applied after the clears so a coincident load or error wins.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_byte_q       <= '0;
      receive_full_q  <= 1'b0;
      fifo_write_rx_q <= 1'b1;
      parity_err_q    <= 1'b0;
      framing_err_q   <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      fifo_write_rx_q <= 1'b1;
      if (read_rx_byte) receive_full_q <= 1'b0;
      if (clear_status) begin
        parity_err_q  <= 1'b0;
        framing_err_q <= 1'b0;
        overflow_q    <= 1'b0;
      end
      if (done_q) begin
        if (!stop_q) framing_err_q <= 1'b1;
        if (perr_q && parity_en) parity_err_q <= 1'b1;
        if (RX_FIFO == 0) begin
          if (!receive_full_q || read_rx_byte) begin
            rx_byte_q      <= data_d;
            receive_full_q <= 1'b1;
          end else begin
            overflow_q <= 1'b1;
          end
        end else begin
          if (!fifo_full) begin
            rx_byte_q       <= data_d;
            fifo_write_rx_q <= 1'b0;
          end else begin
            overflow_q <= 1'b1;
          end
        end
      end
    end
  end

  assign rx_byte       = rx_byte_q;
  assign receive_full  = receive_full_q;
  assign fifo_write_rx = fifo_write_rx_q;
  assign parity_err    = parity_err_q;
  assign framing_err   = framing_err_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_uart_rx_async.sv
// Directed bench for uart_rx_async: one instance per delivery mode sharing the
// same serial line; baud tick every 4 clks, 16 ticks per bit.
module tb_uart_rx_async;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, baud_clock, rx, bit8, parity_en, odd_n_even;
  logic read_rx_byte, clear_status, fifo_full;

  logic [7:0] rx_byte_h, rx_byte_f;
  logic receive_full_h, fifo_write_rx_h, parity_err_h, framing_err_h, overflow_h;
  logic receive_full_f, fifo_write_rx_f, parity_err_f, framing_err_f, overflow_f;

  uart_rx_async #(.RX_FIFO(0)) dut_h (
    .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .rx(rx), .bit8(bit8),
    .parity_en(parity_en), .odd_n_even(odd_n_even), .read_rx_byte(read_rx_byte),
    .clear_status(clear_status), .fifo_full(fifo_full), .rx_byte(rx_byte_h),
    .receive_full(receive_full_h), .fifo_write_rx(fifo_write_rx_h),
    .parity_err(parity_err_h), .framing_err(framing_err_h), .overflow(overflow_h)
  );

  uart_rx_async #(.RX_FIFO(1)) dut_f (
    .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .rx(rx), .bit8(bit8),
    .parity_en(parity_en), .odd_n_even(odd_n_even), .read_rx_byte(read_rx_byte),
    .clear_status(clear_status), .fifo_full(fifo_full), .rx_byte(rx_byte_f),
    .receive_full(receive_full_f), .fifo_write_rx(fifo_write_rx_f),
    .parity_err(parity_err_f), .framing_err(framing_err_f), .overflow(overflow_f)
  );

  typedef struct {
    logic       b8;
    logic       pen;
    logic       odd;
    logic [7:0] data;
    logic       pbit;
    logic       stop;
    logic [7:0] exp_byte;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[8];
  int tests = 0;
  int fails = 0;
  int cyc_n = 0;
  int strobe_cnt = 0;
  logic [7:0] strobe_byte = 8'h00;
  int held_bad = 0;
  logic rfb, rfa;

  function automatic void check1(string name, logic act, logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endfunction

  function automatic void check8(string name, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void checkn(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // One clk; inputs change at the falling edge, outputs are observed there too.
  task automatic step();
    @(negedge clk);
    cyc_n++;
    baud_clock = (cyc_n % 4 == 0);
    if (fifo_write_rx_f === 1'b0) begin
      strobe_cnt++;
      strobe_byte = rx_byte_f;
    end
    if (fifo_write_rx_h !== 1'b1 || receive_full_f !== 1'b0) held_bad++;
  endtask

  task automatic idle_ticks(input int n);
    repeat (4 * n) step();
  endtask

  task automatic pulse_host(input logic rd, input logic clr);
    read_rx_byte = rd;
    clear_status = clr;
    step();
    read_rx_byte = 1'b0;
    clear_status = 1'b0;
  endtask

  // The stop sample tick is tick 26+16*(data+parity bits) after the start edge;
  // completion is the clk after it, i.e. 4*ns cycles after the start edge.
  task automatic send_frame(input logic [7:0] data, input logic nb8, input logic pen,
                            input logic odd, input logic pbit, input logic stop,
                            input bit rd_at_done, input bit rst_bit3,
                            output logic rf_before, output logic rf_after);
    int c, ns, nb, np;
    bit8 = nb8;
    parity_en = pen;
    odd_n_even = odd;
    rf_before = 1'bx;
    rf_after = 1'bx;
    while (cyc_n % 4 != 1) step();
    c = cyc_n;
    nb = nb8 ? 8 : 7;
    np = pen ? 1 : 0;
    ns = 26 + 16 * (nb + np);
    for (int b = 0; b < nb + np + 2; b++) begin
      logic v;
      int len;
      if (b == 0) v = 1'b0;
      else if (b <= nb) v = data[b-1];
      else if (b == nb + 1 && pen) v = pbit;
      else v = stop;
      len = (b == nb + np + 1 && !stop) ? 48 : 64;
      rx = v;
      for (int s = 0; s < len; s++) begin
        if (rst_bit3 && b == 4 && s == 32) begin
          reset_n = 1'b0;
          repeat (3) step();
          rx = 1'b1;
          return;
        end
        if (cyc_n - c == 4 * ns) begin
          rf_before = receive_full_h;
          if (rd_at_done) read_rx_byte = 1'b1;
        end
        step();
        read_rx_byte = 1'b0;
        if (cyc_n - c == 4 * ns + 1) rf_after = receive_full_h;
      end
    end
    rx = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; baud_clock = 1'b0; rx = 1'b1; bit8 = 1'b1; parity_en = 1'b0;
    odd_n_even = 1'b0; read_rx_byte = 1'b0; clear_status = 1'b0; fifo_full = 1'b0;

    //        b8    pen   odd   data   pbit  stop  exp    pe    fe
    vecs[0] = '{1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h41, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 8'h41, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 8'hD5, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};

    repeat (4) step();
    check8("reset rx_byte", rx_byte_h, 8'h00);
    check1("reset receive_full", receive_full_h, 1'b0);
    check1("reset fifo_write_rx", fifo_write_rx_f, 1'b1);
    check1("reset parity_err", parity_err_h, 1'b0);
    check1("reset framing_err", framing_err_h, 1'b0);
    check1("reset overflow", overflow_f, 1'b0);
    reset_n = 1'b1;
    idle_ticks(8);

    for (int i = 0; i < 8; i++) begin
      pulse_host(1'b1, 1'b1);
      strobe_cnt = 0;
      send_frame(vecs[i].data, vecs[i].b8, vecs[i].pen, vecs[i].odd, vecs[i].pbit,
                 vecs[i].stop, 1'b0, 1'b0, rfb, rfa);
      idle_ticks(24);
      $display("vector %0d data %h", i, vecs[i].data);
      check1("vec rf before completion", rfb, 1'b0);
      check1("vec rf one clk after stop", rfa, 1'b1);
      check8("vec rx_byte", rx_byte_h, vecs[i].exp_byte);
      check1("vec receive_full", receive_full_h, 1'b1);
      check1("vec parity_err", parity_err_h, vecs[i].exp_pe);
      check1("vec framing_err", framing_err_h, vecs[i].exp_fe);
      check1("vec overflow", overflow_h, 1'b0);
      checkn("vec fifo strobes", strobe_cnt, 1);
      check8("vec fifo strobe byte", strobe_byte, vecs[i].exp_byte);
    end

    pulse_host(1'b0, 1'b1);
    check1("framing_err cleared", framing_err_h, 1'b0);

    // Overrun in holding mode, then a read coincident with completion.
    pulse_host(1'b1, 1'b1);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, rfb, rfa);
    idle_ticks(24);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, rfb, rfa);
    idle_ticks(24);
    check8("ovf rx_byte kept", rx_byte_h, 8'h11);
    check1("ovf overflow set", overflow_h, 1'b1);
    check1("ovf receive_full", receive_full_h, 1'b1);
    pulse_host(1'b0, 1'b1);
    check1("ovf cleared", overflow_h, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, rfb, rfa);
    idle_ticks(24);
    check1("rd coincident rf before", rfb, 1'b1);
    check1("rd coincident rf after", rfa, 1'b1);
    check8("rd coincident rx_byte", rx_byte_h, 8'h22);
    check1("rd coincident overflow", overflow_h, 1'b0);
    pulse_host(1'b1, 1'b0);
    check1("read clears receive_full", receive_full_h, 1'b0);

    // FIFO mode: strobe when room, overrun when full.
    pulse_host(1'b1, 1'b1);
    fifo_full = 1'b0;
    strobe_cnt = 0;
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, rfb, rfa);
    idle_ticks(24);
    checkn("fifo strobe count", strobe_cnt, 1);
    check8("fifo strobe byte", strobe_byte, 8'h7E);
    check8("fifo rx_byte", rx_byte_f, 8'h7E);
    check1("fifo overflow clear", overflow_f, 1'b0);
    fifo_full = 1'b1;
    strobe_cnt = 0;
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, rfb, rfa);
    idle_ticks(24);
    fifo_full = 1'b0;
    checkn("fifo full no strobe", strobe_cnt, 0);
    check1("fifo full overflow", overflow_f, 1'b1);
    check8("fifo full rx_byte kept", rx_byte_f, 8'h7E);

    // Short low glitch must not start a frame.
    pulse_host(1'b1, 1'b1);
    strobe_cnt = 0;
    while (cyc_n % 4 != 1) step();
    rx = 1'b0;
    repeat (20) step();
    rx = 1'b1;
    idle_ticks(40);
    check1("glitch receive_full", receive_full_h, 1'b0);
    checkn("glitch no strobe", strobe_cnt, 0);
    check8("glitch rx_byte kept", rx_byte_h, 8'h7E);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rfb, rfa);
    idle_ticks(24);
    check8("post glitch rx_byte", rx_byte_h, 8'h5A);
    check1("post glitch framing_err", framing_err_f, 1'b1);

    // Reset during data bit 3 aborts the frame.
    strobe_cnt = 0;
    send_frame(8'h99, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, rfb, rfa);
    check8("midreset rx_byte h", rx_byte_h, 8'h00);
    check8("midreset rx_byte f", rx_byte_f, 8'h00);
    check1("midreset receive_full", receive_full_h, 1'b0);
    check1("midreset fifo_write_rx", fifo_write_rx_f, 1'b1);
    check1("midreset framing_err h", framing_err_h, 1'b0);
    check1("midreset framing_err f", framing_err_f, 1'b0);
    check1("midreset parity_err", parity_err_f, 1'b0);
    check1("midreset overflow", overflow_h, 1'b0);
    reset_n = 1'b1;
    idle_ticks(30);
    checkn("midreset no strobe", strobe_cnt, 0);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, rfb, rfa);
    idle_ticks(24);
    check8("after reset rx_byte", rx_byte_h, 8'h55);
    check1("after reset receive_full", receive_full_h, 1'b1);
    check1("after reset framing_err", framing_err_h, 1'b0);
    checkn("after reset strobe", strobe_cnt, 1);
    check8("after reset strobe byte", strobe_byte, 8'h55);

    checkn("held outputs constant", held_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
